// File: rtl/cam_pkg.sv
// cam_pkg: shared capture FSM states and frame-geometry helpers for the
// camera-to-frame-buffer path.
package cam_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_FS,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  localparam int XY_W = 10;

  function automatic int frame_pixels(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  function automatic bit addr_w_fits(input int addr_w, input int h_res, input int v_res);
    return (longint'(1) << addr_w) >= longint'(frame_pixels(h_res, v_res));
  endfunction
endpackage

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: registered x/y to linear buffer address for scan-out
// consumers, with an in-range qualifier gated by an external enable.
module frame_addr_gen
  import cam_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [XY_W-1:0]   x,
  input  logic [XY_W-1:0]   y,
  output logic [ADDR_W-1:0] addr_q,
  output logic              valid_q
);
  localparam logic [31:0] H_K = 32'(H_RES);
  localparam logic [31:0] V_K = 32'(V_RES);

  logic              in_range;
  logic [ADDR_W-1:0] prod;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;

  // Constant multiply unrolled into one shifted add per set bit of H_RES.
  always_comb begin
    prod = ADDR_W'(x);
    for (int i = 0; i < 32; i++) prod = H_K[i] ? prod + (ADDR_W'(y) << i) : prod;
    in_range = (32'(x) < H_K) && (32'(y) < V_K);
    addr_d = in_range ? prod : '0;
    valid_d = en && in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: single-shot / continuous frame capture into the frame
// buffer with frame skipping, short-frame and overflow flags, plus scan-out read.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_req,
  input  logic              continuous,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic [XY_W-1:0]   disp_x,
  input  logic [XY_W-1:0]   disp_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              disp_valid,
  output logic              busy,
  output logic              done,
  output logic              short_frame,
  output logic              overflow
);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SKIP_W = $clog2(SKIP_FRAMES + 1) + 1;
  localparam logic [CNT_W-1:0]  FP_C   = CNT_W'(frame_pixels(H_RES, V_RES));
  localparam logic [SKIP_W-1:0] SKIP_C = SKIP_W'(SKIP_FRAMES);

  if (!addr_w_fits(ADDR_W, H_RES, V_RES)) begin : g_addr_w_check
    $error("frame_capture_ctrl: ADDR_W too small for H_RES*V_RES");
  end

  cap_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, base;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;
  logic              cont_q, cont_d;
  logic              arm, cap_act, wr_ok;

  // A frame_start seen while capturing (or arriving in WAIT_FS) restarts the
  // count, so the pixel sharing that cycle lands at address 0.
  always_comb begin
    arm       = capture_req && (state_q == ST_IDLE || (state_q == ST_DONE && !cont_q));
    cap_act   = (state_q == ST_CAPTURE) || (state_q == ST_WAIT_FS && frame_start);
    base      = frame_start ? '0 : cnt_q;
    wr_ok     = cap_act && pix_valid && (base < FP_C);
    cnt_d     = cap_act ? base + CNT_W'(wr_ok) : cnt_q;
    wr_en_d   = wr_ok;
    wr_addr_d = wr_ok ? base[ADDR_W-1:0] : wr_addr_q;
    wr_data_d = wr_ok ? pix_data : wr_data_q;
    ovf_d     = !arm && (ovf_q || (cap_act && pix_valid && !wr_ok));
    short_d   = !arm && (short_q || (state_q == ST_CAPTURE &&
                ((frame_start && cnt_q < FP_C) || (frame_end && cnt_d < FP_C))));
    done_d    = (done_q && !(state_q == ST_WAIT_FS && frame_start)) ||
                (state_q == ST_CAPTURE && frame_end);
    cont_d    = (state_q == ST_CAPTURE && frame_end) ? continuous : cont_q;
    skip_d    = arm ? '0 : (state_q == ST_SKIP && frame_end) ? skip_q + 1'b1 : skip_q;
    state_d   = state_q;
    if (arm) state_d = (SKIP_FRAMES > 0) ? ST_SKIP : ST_WAIT_FS;
    else if (state_q == ST_SKIP && frame_end && skip_d == SKIP_C) state_d = ST_WAIT_FS;
    else if (state_q == ST_WAIT_FS && frame_start) state_d = ST_CAPTURE;
    else if (state_q == ST_CAPTURE && frame_end) state_d = ST_DONE;
    else if (state_q == ST_DONE && cont_q) state_d = ST_WAIT_FS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cont_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      short_q   <= short_d;
      ovf_q     <= ovf_d;
      cont_q    <= cont_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign short_frame = short_q;
  assign overflow    = ovf_q;
  assign busy        = state_q inside {ST_SKIP, ST_WAIT_FS, ST_CAPTURE};

  frame_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_rd_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (done_q),
    .x      (disp_x),
    .y      (disp_y),
    .addr_q (rd_addr),
    .valid_q(disp_valid)
  );
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: randomized frame traffic on a reduced 20x10 geometry;
// expected buffer writes come from a per-frame list of sent pixels.
module tb_frame_capture_ctrl;
  localparam int H = 20, V = 10, AW = 8, DW = 24, SK = 2, FP = H * V;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          capture_req = 1'b0, continuous = 1'b0;
  logic          frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [9:0]    disp_x = '0, disp_y = '0;
  logic          wr_en, disp_valid, busy, done, short_frame, overflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  int vectors = 0, miscompares = 0;
  logic [AW-1:0] wa[$], ea[$];
  logic [DW-1:0] wd[$], ed[$], sent[$];

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .SKIP_FRAMES(SK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .capture_req(capture_req), .continuous(continuous),
    .frame_start(frame_start), .frame_end(frame_end), .pix_valid(pix_valid),
    .pix_data(pix_data), .disp_x(disp_x), .disp_y(disp_y), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .disp_valid(disp_valid),
    .busy(busy), .done(done), .short_frame(short_frame), .overflow(overflow)
  );

  always @(negedge clk) if (rst_n && wr_en) begin
    wa.push_back(wr_addr);
    wd.push_back(wr_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); ea.delete(); ed.delete(); sent.delete();
  endtask

  // A captured frame lands at consecutive addresses from 0, truncated to FP.
  function automatic void expect_frame();
    for (int i = 0; i < sent.size() && i < FP; i++) begin
      ea.push_back(AW'(i));
      ed.push_back(sent[i]);
    end
    sent.delete();
  endfunction

  task automatic send_frame(input int n, input bit fe);
    int k = 0;
    bit ended = 1'b0;
    frame_start = 1'b1;
    if (n > 0 && $urandom_range(1, 0) == 1) begin
      pix_valid = 1'b1; pix_data = DW'($urandom); sent.push_back(pix_data); k++;
    end
    cyc();
    frame_start = 1'b0; pix_valid = 1'b0;
    while (k < n) begin
      if ($urandom_range(3, 0) != 0) begin
        pix_valid = 1'b1; pix_data = DW'($urandom); sent.push_back(pix_data); k++;
        if (k == n && fe && $urandom_range(1, 0) == 1) begin frame_end = 1'b1; ended = 1'b1; end
      end
      cyc();
      pix_valid = 1'b0; frame_end = 1'b0;
    end
    if (fe && !ended) begin frame_end = 1'b1; cyc(); frame_end = 1'b0; end
    repeat (2) cyc();
  endtask

  task automatic arm();
    capture_req = 1'b1; cyc(); capture_req = 1'b0;
  endtask

  task automatic skip_frames();
    repeat (SK) send_frame($urandom_range(FP + 5, 1), 1'b1);
    sent.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_x = 10'(H - 1); disp_y = 10'(V - 1);
    repeat (3) cyc();
    vectors++; if ({wr_en, busy, done, short_frame, overflow, disp_valid} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b exp 000000", {wr_en, busy, done, short_frame, overflow, disp_valid}); end
    vectors++; if (rd_addr !== '0 || wr_addr !== '0) begin
      miscompares++; $display("FAIL reset_addr: got rd %0d wr %0d exp 0 0", rd_addr, wr_addr); end
    rst_n = 1'b1; cyc(); cyc();
    vectors++; if (rd_addr !== AW'(FP - 1) || disp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_read: got rd %0d valid %b exp %0d 0", rd_addr, disp_valid, FP - 1); end
  endtask

  task automatic test_skip();
    clear(); arm();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL skip_busy: got %b exp 1", busy); end
    capture_req = 1'b1; cyc(); capture_req = 1'b0;
    skip_frames(); send_frame(FP, 1'b1); expect_frame(); repeat (3) cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL skip_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL skip_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    vectors++; if ({done, short_frame, overflow, busy} !== 4'b1000) begin
      miscompares++; $display("FAIL skip_flags: got %b exp 1000", {done, short_frame, overflow, busy}); end
  endtask

  task automatic test_short();
    clear(); arm(); skip_frames(); send_frame(37, 1'b1); expect_frame();
    pix_valid = 1'b1; repeat (3) cyc(); pix_valid = 1'b0; cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL short_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL short_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    vectors++; if (wa.size() == 0 || wa[$] !== AW'(36)) begin
      miscompares++; $display("FAIL short_last: got %0d exp 36", wa.size() ? wa[$] : '0); end
    vectors++; if ({done, short_frame, overflow} !== 3'b110) begin
      miscompares++; $display("FAIL short_flags: got %b exp 110", {done, short_frame, overflow}); end
  endtask

  task automatic test_overflow();
    int beyond = 0;
    clear(); arm(); skip_frames(); send_frame(FP + 10, 1'b1); expect_frame(); cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL ovf_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL ovf_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    foreach (wa[i]) if (int'(wa[i]) >= FP) beyond++;
    vectors++; if (beyond != 0) begin miscompares++; $display("FAIL ovf_beyond: got %0d exp 0", beyond); end
    vectors++; if ({done, short_frame, overflow} !== 3'b101) begin
      miscompares++; $display("FAIL ovf_flags: got %b exp 101", {done, short_frame, overflow}); end
  endtask

  task automatic test_missed_fe();
    clear(); arm(); skip_frames();
    send_frame(15, 1'b0); expect_frame();
    send_frame(FP, 1'b1); expect_frame(); cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL mfe_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL mfe_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    vectors++; if ({done, short_frame, overflow} !== 3'b110) begin
      miscompares++; $display("FAIL mfe_flags: got %b exp 110", {done, short_frame, overflow}); end
  endtask

  task automatic test_read();
    for (int i = 0; i < 30; i++) begin
      int x, y, ea_r;
      bit ev;
      x = (i == 0) ? H - 1 : (i == 1) ? H : (i == 2) ? 0 : $urandom_range(H + 3, 0);
      y = (i == 0 || i == 1) ? V - 1 : (i == 2) ? V : $urandom_range(V + 3, 0);
      ev = (x < H) && (y < V);
      ea_r = ev ? y * H + x : 0;
      disp_x = 10'(x); disp_y = 10'(y);
      cyc();
      vectors++; if (rd_addr !== AW'(ea_r) || disp_valid !== ev) begin
        miscompares++; $display("FAIL read(%0d,%0d): got %0d/%b exp %0d/%b", x, y, rd_addr, disp_valid, ea_r, ev); end
    end
  endtask

  task automatic test_continuous();
    clear(); continuous = 1'b1; arm(); skip_frames();
    send_frame(FP, 1'b1); expect_frame(); repeat (3) cyc();
    vectors++; if ({done, busy} !== 2'b11) begin
      miscompares++; $display("FAIL cont_between: got done/busy %b exp 11", {done, busy}); end
    send_frame(FP, 1'b1); expect_frame();
    continuous = 1'b0;
    send_frame(50, 1'b1); expect_frame(); repeat (4) cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL cont_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL cont_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    vectors++; if ({done, busy, short_frame} !== 3'b101) begin
      miscompares++; $display("FAIL cont_end: got %b exp 101", {done, busy, short_frame}); end
  endtask

  task automatic test_reset_mid();
    clear(); arm(); skip_frames();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    pix_valid = 1'b1;
    repeat (5) begin pix_data = DW'($urandom); cyc(); end
    pix_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    vectors++; if ({wr_en, busy, done} !== 3'b000) begin
      miscompares++; $display("FAIL rstmid_now: got %b exp 000", {wr_en, busy, done}); end
    @(negedge clk); rst_n = 1'b1; cyc();
    clear(); arm(); skip_frames(); send_frame(FP, 1'b1); expect_frame(); repeat (3) cyc();
    vectors++; if (wa.size() != ea.size()) begin
      miscompares++; $display("FAIL rstmid_count: got %0d exp %0d", wa.size(), ea.size()); end
    foreach (ea[i]) begin
      vectors++; if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++; $display("FAIL rstmid_wr[%0d]: got %0d/%h exp %0d/%h", i, wa[i], wd[i], ea[i], ed[i]); end
    end
    vectors++; if ({done, short_frame, overflow, busy} !== 4'b1000) begin
      miscompares++; $display("FAIL rstmid_flags: got %b exp 1000", {done, short_frame, overflow, busy}); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_short();
    test_overflow();
    test_missed_fe();
    test_read();
    test_continuous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
